// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: EX/MEM pipeline register with stall hold and flush bubble.
module ex_mem_pipe_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] pc_ex,
  input  logic [31:0] pc_plus_4_ex,
  input  logic [4:0]  rd_ex,
  input  logic        im_to_rf_ex,
  input  logic        store_ex,
  input  logic        load_ex,
  input  logic [1:0]  next_pc_selector_ex,
  input  logic [31:0] rs2_data_ex,
  input  logic [31:0] uj_type_ex,
  input  logic [31:0] alu_data_ex,
  input  logic [31:0] jump_i_type_ex,
  input  logic [31:0] jump_sb_type_ex,
  output logic [31:0] pc_mem,
  output logic [31:0] pc_plus_4_mem,
  output logic [4:0]  rd_mem,
  output logic        im_to_rf_mem,
  output logic        store_mem,
  output logic        load_mem,
  output logic [1:0]  next_pc_selector_mem,
  output logic [31:0] rs2_data_mem,
  output logic [31:0] uj_type_mem,
  output logic [31:0] alu_data_mem,
  output logic [31:0] jump_i_type_mem,
  output logic [31:0] jump_sb_type_mem
);
  localparam int W = 234;
  logic [W-1:0] d, q;
  // One flop bank for every field so all outputs update in the same edge.
  assign d = {pc_ex, pc_plus_4_ex, rd_ex, im_to_rf_ex, store_ex, load_ex, next_pc_selector_ex,
              rs2_data_ex, uj_type_ex, alu_data_ex, jump_i_type_ex, jump_sb_type_ex};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (flush) q <= '0;
    else if (!stall) q <= d;
  assign {pc_mem, pc_plus_4_mem, rd_mem, im_to_rf_mem, store_mem, load_mem, next_pc_selector_mem,
          rs2_data_mem, uj_type_mem, alu_data_mem, jump_i_type_mem, jump_sb_type_mem} = q;
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb_ex_mem_pipe_reg: vector table plus scoreboard bench for the EX/MEM pipeline register.
module tb_ex_mem_pipe_reg;
  typedef struct packed {
    logic [31:0] pc, pc4;
    logic [4:0]  rd;
    logic        imrf, st, ld;
    logic [1:0]  nps;
    logic [31:0] rs2, uj, alu, ji, jsb;
  } bundle_t;
  typedef struct {
    logic    stall;
    logic    flush;
    bundle_t din;
    bundle_t exp;
  } vec_t;

  logic clk = 0, rst_n = 0, stall = 0, flush = 0;
  bundle_t din = '0, dout, model = '0, zero = '0;
  logic [31:0] pc_mem, pc_plus_4_mem, rs2_data_mem, uj_type_mem, alu_data_mem, jump_i_type_mem, jump_sb_type_mem;
  logic [4:0]  rd_mem;
  logic        im_to_rf_mem, store_mem, load_mem;
  logic [1:0]  next_pc_selector_mem;
  bundle_t sb[$];
  int n = 0, fails = 0;

  always #10 clk = ~clk;

  ex_mem_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .pc_ex(din.pc), .pc_plus_4_ex(din.pc4), .rd_ex(din.rd), .im_to_rf_ex(din.imrf),
    .store_ex(din.st), .load_ex(din.ld), .next_pc_selector_ex(din.nps),
    .rs2_data_ex(din.rs2), .uj_type_ex(din.uj), .alu_data_ex(din.alu),
    .jump_i_type_ex(din.ji), .jump_sb_type_ex(din.jsb),
    .pc_mem(pc_mem), .pc_plus_4_mem(pc_plus_4_mem), .rd_mem(rd_mem), .im_to_rf_mem(im_to_rf_mem),
    .store_mem(store_mem), .load_mem(load_mem), .next_pc_selector_mem(next_pc_selector_mem),
    .rs2_data_mem(rs2_data_mem), .uj_type_mem(uj_type_mem), .alu_data_mem(alu_data_mem),
    .jump_i_type_mem(jump_i_type_mem), .jump_sb_type_mem(jump_sb_type_mem)
  );

  assign dout = {pc_mem, pc_plus_4_mem, rd_mem, im_to_rf_mem, store_mem, load_mem, next_pc_selector_mem,
                 rs2_data_mem, uj_type_mem, alu_data_mem, jump_i_type_mem, jump_sb_type_mem};

  function automatic bundle_t mk(input logic [31:0] s);
    bundle_t b;
    b.pc = s; b.pc4 = s + 32'd4; b.rd = s[4:0]; b.imrf = s[5]; b.st = s[6]; b.ld = s[7];
    b.nps = s[9:8]; b.rs2 = s ^ 32'hA5A5_A5A5; b.uj = ~s; b.alu = {s[15:0], s[31:16]};
    b.ji = s + 32'h100; b.jsb = s - 32'h40;
    return b;
  endfunction

  function automatic bundle_t rnd();
    bundle_t b;
    b.pc = $urandom(); b.pc4 = $urandom(); b.rd = 5'($urandom()); b.imrf = 1'($urandom());
    b.st = 1'($urandom()); b.ld = 1'($urandom()); b.nps = 2'($urandom());
    b.rs2 = $urandom(); b.uj = $urandom(); b.alu = $urandom(); b.ji = $urandom(); b.jsb = $urandom();
    return b;
  endfunction

  task automatic check(input string name, input bundle_t act, input bundle_t exp);
    n++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic f, input bundle_t d, input bundle_t e, input string name);
    stall = s; flush = f; din = d;
    sb.push_back(e);
    model = e;
    @(posedge clk); #1;
    check(name, dout, sb.pop_front());
  endtask

  vec_t vt[8];
  bundle_t a, b, c, dd, e, basic, x1, x2, r, ex;
  logic s, f;

  initial begin
    a = mk(32'h0000_0040); a.rd = 5'd3; a.st = 1'b1;
    b = mk(32'h1111_2222);
    c = mk(32'h3333_4444);
    dd = mk(32'h5555_6666); dd.ld = 1'b1; dd.alu = 32'hFFFF_FFFF;
    e = mk(32'h7777_8888);
    vt[0] = '{1'b0, 1'b0, a, a};
    vt[1] = '{1'b1, 1'b0, b, a};
    vt[2] = '{1'b1, 1'b0, c, a};
    vt[3] = '{1'b0, 1'b0, c, c};
    vt[4] = '{1'b1, 1'b1, dd, zero};
    vt[5] = '{1'b0, 1'b0, e, e};
    vt[6] = '{1'b0, 1'b1, e, zero};
    vt[7] = '{1'b0, 1'b0, a, a};

    din = mk(32'h0000_1000); din.rd = 5'd7; din.ld = 1'b1;
    @(posedge clk); #1; check("reset_hold_0", dout, zero);
    @(posedge clk); #1; check("reset_hold_1", dout, zero);
    @(negedge clk); rst_n = 1;

    basic = mk(32'h1234_5678); basic.pc4 = 32'h1234_567C; basic.rd = 5'd31;
    basic.nps = 2'b11; basic.alu = 32'hDEAD_BEEF;
    din = basic;
    #1 check("pre_edge", dout, zero);
    @(posedge clk); #1; check("basic_capture", dout, basic);

    x1 = mk(32'h0BAD_F00D); x2 = mk(32'hCAFE_0001);
    #4 din = x1;
    #5 check("mid_hold", dout, basic);
    #5 din = x2;
    @(posedge clk); #1; check("mid_edge_value", dout, x2);

    #4 rst_n = 0;
    #1 check("async_reset", dout, zero);
    model = zero;
    @(negedge clk); rst_n = 1;

    for (int i = 0; i < 8; i++) step(vt[i].stall, vt[i].flush, vt[i].din, vt[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 5; i++) begin
      r = rnd();
      step(1'b0, 1'b0, r, r, $sformatf("stream%0d", i));
    end
    for (int i = 0; i < 12; i++) begin
      r = rnd();
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 4) == 0);
      ex = f ? zero : s ? model : r;
      step(s, f, r, ex, $sformatf("mix%0d", i));
    end

    n++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule
